pbs_turn_ctrl: RTL and testbench
================================

Name: pbs_turn_ctrl

Overview:
- Battle-turn controller FSM that sits directly upstream of the battle datapath.
- Converts the player's confirm button into the datapath strobes: actr, target, load_ai_hp, app_ai_dmg, app_pl_dmg and stop.
- Sequences one player half-turn then one AI half-turn, gates damage on the accuracy roll, detects KO, and counts turns.
- Reads back hp/dmg/accu from the datapath and a 4-bit accuracy roll from the RNG bank.

Parameters:
- TURN_W, 8, width of the turn counter.
- MAX_TURNS, 20, turn limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- go  in  1  raw player-confirm button, asynchronous, active-high
- p_hp  in  4  player HP from datapath
- ai_hp  in  4  AI HP from datapath
- dmg  in  4  damage of currently selected move
- accu  in  4  accuracy of currently selected move
- acc_roll  in  4  accuracy random roll
- actr  out  1  0 = player move selected, 1 = AI move selected
- target  out  1  0 = player is target, 1 = AI is target
- load_ai_hp  out  1  latch AI HP into datapath working register
- app_ai_dmg  out  1  write AI HP
- app_pl_dmg  out  1  write player HP
- stop  out  1  freeze RNGs
- busy  out  1  turn in progress
- last_hit  out  2  {ai_hit, pl_hit} of most recent evaluations
- p_win  out  1  AI knocked out
- ai_win  out  1  player knocked out
- draw  out  1  turn limit reached
- turn_cnt  out  TURN_W  completed turns

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to WAIT_GO.
  - All outputs 0, turn_cnt=0, sync flops 0.
  - Reset mid-turn aborts immediately; no strobe is issued on the following cycle.
- go input path:
  - 2-flop synchronizer, then rising-edge detect (go_edge, 1-cycle pulse).
  - P_SEL is entered on the 3rd posedge after go rises.
  - Holding go high gives exactly one edge.
  - Edges outside WAIT_GO are discarded, not queued.
- Output decode is Moore (decoded from state only). States and transitions:
  - WAIT_GO: busy=0, stop=0. go_edge goes to P_SEL.
  - P_SEL: actr=0, target=1, stop=1, busy=1. Always goes to P_EVAL; this cycle covers the datapath's registered move mux.
  - P_EVAL: actr=0, target=1, stop=1, load_ai_hp=1.
    - pl_hit = (accu >= acc_roll), unsigned; stored in last_hit[0].
    - pl_hit goes to P_APPLY, otherwise A_SEL.
  - P_APPLY: target=1, stop=1, app_ai_dmg=1.
    - If dmg >= ai_hp, set p_win and go to DONE; otherwise go to A_SEL.
  - A_SEL: actr=1, target=0, stop=1. Always goes to A_EVAL.
  - A_EVAL: actr=1, target=0, stop=1.
    - ai_hit = (accu >= acc_roll); stored in last_hit[1].
    - ai_hit goes to A_APPLY, otherwise T_END.
  - A_APPLY: actr=1, target=0, stop=1, app_pl_dmg=1.
    - If dmg >= p_hp, set ai_win and go to DONE; otherwise go to T_END.
  - T_END: stop=0. turn_cnt increments, saturating at 2^TURN_W-1. Goes to WAIT_GO.
  - DONE: busy=0, stop=0, strobes 0. Win/draw flags held. Absorbing state; ignores go; exits only via rst.
- Strobe rules:
  - At most one of load_ai_hp/app_ai_dmg/app_pl_dmg is high per cycle.
  - Each strobe is exactly 1 cycle wide.
- Timing:
  - Minimum full turn (both hit, no KO) is 7 cycles: P_SEL..T_END.
  - Double miss takes 5 cycles.
- KO and boundary cases:
  - KO compare is 4-bit unsigned.
  - dmg==0 never KOs unless hp is already 0.
  - hp==0 with any hit gives KO.
  - p_win and ai_win are mutually exclusive; the player always strikes first.
- acc_roll is sampled only in the EVAL states; stop high holds it stable.

Optional Feature:
- Macro: TURN_LIMIT_EN.
- Defined: in T_END, if turn_cnt+1 == MAX_TURNS, set draw=1 and go to DONE instead of WAIT_GO.
- Not defined: draw is tied 0 and the counter only saturates.

Test Plan:
- Reset then go pulse, accu=15, acc_roll=0, dmg=3, ai_hp=15, p_hp=15:
  - load_ai_hp, app_ai_dmg, app_pl_dmg each pulse once, in that order.
  - turn_cnt=1, last_hit=2'b11, back in WAIT_GO.
- accu=2, acc_roll=9 for both sides: no app_* strobes, last_hit=2'b00, turn_cnt increments, 5-cycle busy window.
- ai_hp=3, dmg=3, player hit: p_win=1 after P_APPLY, no A_SEL; further go pulses are ignored; rst clears p_win.
- go held high for 50 cycles: exactly one turn. go re-pulsed while busy: no extra turn.
- rst asserted during A_EVAL: next cycle all outputs 0, state WAIT_GO, no app_pl_dmg pulse.
- TURN_LIMIT_EN with MAX_TURNS=3, all misses: after the 3rd turn draw=1, busy=0, turn_cnt=3.

Source files
------------

// File: rtl/pbs_turn_ctrl_if.sv
// pbs_turn_ctrl_if: link between the battle-turn controller and the battle
// datapath/RNG bank. The controller is the master: it reads HP, move damage,
// move accuracy and the accuracy roll, and drives the move-select and
// HP-write strobes.
interface pbs_turn_ctrl_if;
   logic [3:0] p_hp;        // player HP
   logic [3:0] ai_hp;       // AI HP
   logic [3:0] dmg;         // damage of the selected move
   logic [3:0] accu;        // accuracy of the selected move
   logic [3:0] acc_roll;    // accuracy random roll
   logic       actr;        // 0 = player move selected, 1 = AI move selected
   logic       target;      // 0 = player is target, 1 = AI is target
   logic       load_ai_hp;  // latch AI HP into the working register
   logic       app_ai_dmg;  // write AI HP
   logic       app_pl_dmg;  // write player HP
   logic       stop;        // freeze the RNGs

   modport master (
      input  p_hp, ai_hp, dmg, accu, acc_roll,
      output actr, target, load_ai_hp, app_ai_dmg, app_pl_dmg, stop
   );

   modport slave (
      output p_hp, ai_hp, dmg, accu, acc_roll,
      input  actr, target, load_ai_hp, app_ai_dmg, app_pl_dmg, stop
   );
endinterface

// File: rtl/pbs_turn_ctrl.sv
// pbs_turn_ctrl: battle-turn controller. A synchronised press of the confirm
// button runs one player half-turn then one AI half-turn, gating damage on
// the accuracy roll, detecting KO and counting completed turns.
// Optional feature: define TURN_LIMIT_EN to end the battle in a draw once
// MAX_TURNS turns have completed; otherwise draw is tied low and the turn
// counter just saturates.
module pbs_turn_ctrl #(
   parameter int TURN_W    = 8,
   parameter int MAX_TURNS = 20
) (
   input  logic              clk,
   input  logic              rst,       // synchronous, active-low
   input  logic              go,        // raw confirm button, asynchronous
   pbs_turn_ctrl_if.master   dp,
   output logic              busy,
   output logic [1:0]        last_hit,  // {ai_hit, pl_hit}
   output logic              p_win,
   output logic              ai_win,
   output logic              draw,
   output logic [TURN_W-1:0] turn_cnt
);

   localparam logic [3:0] WAIT_GO = 4'd0;
   localparam logic [3:0] P_SEL   = 4'd1;
   localparam logic [3:0] P_EVAL  = 4'd2;
   localparam logic [3:0] P_APPLY = 4'd3;
   localparam logic [3:0] A_SEL   = 4'd4;
   localparam logic [3:0] A_EVAL  = 4'd5;
   localparam logic [3:0] A_APPLY = 4'd6;
   localparam logic [3:0] T_END   = 4'd7;
   localparam logic [3:0] DONE    = 4'd8;

   logic [3:0] state;
   logic [3:0] state_nx;
   logic [1:0] go_sync;
   logic       go_hist;
   logic       go_edge;
   logic       hit;
   logic       ai_ko;
   logic       pl_ko;
   logic       limit_hit;

   // The selected move (player's or AI's, via actr) is compared against the
   // frozen roll; the same compare serves both EVAL states.
   assign hit   = (dp.accu >= dp.acc_roll);
   assign ai_ko = (dp.dmg >= dp.ai_hp);
   assign pl_ko = (dp.dmg >= dp.p_hp);

`ifdef TURN_LIMIT_EN
   assign limit_hit = ((int'(turn_cnt) + 1) == MAX_TURNS);
`else
   logic unused_max_turns;
   assign limit_hit        = 1'b0;
   assign draw             = 1'b0;
   assign unused_max_turns = (MAX_TURNS > 0);
`endif

   // Two-flop synchroniser for the button plus one history flop for the edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the sync chain.
      if (!rst) begin
         go_sync <= 2'b00;
         go_hist <= 1'b0;
      end else begin
         go_sync <= {go_sync[0], go};
         go_hist <= go_sync[1];
      end
   end

   assign go_edge = go_sync[1] & ~go_hist;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= WAIT_GO;
      else      state <= state_nx;
   end

   // Next-state logic; DONE is absorbing and only rst leaves it.
   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch forms.
      state_nx = state;
      case (state)
         WAIT_GO: if (go_edge) state_nx = P_SEL;
         P_SEL:   state_nx = P_EVAL;
         P_EVAL:  state_nx = hit ? P_APPLY : A_SEL;
         P_APPLY: state_nx = ai_ko ? DONE : A_SEL;
         A_SEL:   state_nx = A_EVAL;
         A_EVAL:  state_nx = hit ? A_APPLY : T_END;
         A_APPLY: state_nx = pl_ko ? DONE : T_END;
         T_END:   state_nx = limit_hit ? DONE : WAIT_GO;
         DONE:    state_nx = DONE;
         default: state_nx = WAIT_GO;
      endcase
   end

   // Hit history, KO flags and the saturating turn counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_hit <= 2'b00;
         p_win    <= 1'b0;
         ai_win   <= 1'b0;
         turn_cnt <= '0;
      end else begin
         if (state == P_EVAL)           last_hit[0] <= hit;
         if (state == A_EVAL)           last_hit[1] <= hit;
         if (state == P_APPLY && ai_ko) p_win       <= 1'b1;
         if (state == A_APPLY && pl_ko) ai_win      <= 1'b1;
         if (state == T_END && turn_cnt != '1) turn_cnt <= turn_cnt + 1'b1;
      end
   end

`ifdef TURN_LIMIT_EN
   // Draw flag, raised as the limiting turn ends and held in DONE.
   always_ff @(posedge clk) begin
      if (!rst)                          draw <= 1'b0;
      else if (state == T_END && limit_hit) draw <= 1'b1;
   end
`endif

   // Moore output decode: strobes depend on the state alone.
   always_comb begin
      dp.actr       = 1'b0;
      dp.target     = 1'b0;
      dp.load_ai_hp = 1'b0;
      dp.app_ai_dmg = 1'b0;
      dp.app_pl_dmg = 1'b0;
      dp.stop       = 1'b0;
      busy          = 1'b0;
      case (state)
         P_SEL: begin
            dp.target = 1'b1;
            dp.stop   = 1'b1;
            busy      = 1'b1;
         end
         P_EVAL: begin
            dp.target     = 1'b1;
            dp.stop       = 1'b1;
            dp.load_ai_hp = 1'b1;
            busy          = 1'b1;
         end
         P_APPLY: begin
            dp.target     = 1'b1;
            dp.stop       = 1'b1;
            dp.app_ai_dmg = 1'b1;
            busy          = 1'b1;
         end
         A_SEL, A_EVAL: begin
            dp.actr = 1'b1;
            dp.stop = 1'b1;
            busy    = 1'b1;
         end
         A_APPLY: begin
            dp.actr       = 1'b1;
            dp.stop       = 1'b1;
            dp.app_pl_dmg = 1'b1;
            busy          = 1'b1;
         end
         T_END:   busy = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// tb_pbs_turn_ctrl: directed and randomised turns against a trace-level
// reference model of the battle-turn controller.
module tb_pbs_turn_ctrl;
   localparam int TURN_W = 8;
`ifdef TURN_LIMIT_EN
   localparam int MAX_TURNS = 3;
`else
   localparam int MAX_TURNS = 20;
`endif
   localparam int CNT_MAX = (1 << TURN_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              go;
   logic              busy;
   logic [1:0]        last_hit;
   logic              p_win;
   logic              ai_win;
   logic              draw;
   logic [TURN_W-1:0] turn_cnt;

   pbs_turn_ctrl_if dp_if ();

   pbs_turn_ctrl #(.TURN_W(TURN_W), .MAX_TURNS(MAX_TURNS)) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .dp       (dp_if),
      .busy     (busy),
      .last_hit (last_hit),
      .p_win    (p_win),
      .ai_win   (ai_win),
      .draw     (draw),
      .turn_cnt (turn_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model state.
   int       m_turns;
   bit [1:0] m_last_hit;
   bit       m_p_win;
   bit       m_ai_win;
   bit       m_draw;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed hang, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Observable strobe vector: {actr, target, load_ai_hp, app_ai_dmg, app_pl_dmg, stop}.
   function automatic logic [5:0] strobes();
      return {dp_if.actr, dp_if.target, dp_if.load_ai_hp,
              dp_if.app_ai_dmg, dp_if.app_pl_dmg, dp_if.stop};
   endfunction

   task automatic model_reset();
      m_turns    = 0;
      m_last_hit = 2'b00;
      m_p_win    = 1'b0;
      m_ai_win   = 1'b0;
      m_draw     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      go  = 1'b0;
      tick();
      tick();
      check("reset_outputs",
            32'({busy, last_hit, p_win, ai_win, draw, turn_cnt, strobes()}), 32'd0);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic set_inputs(input int php, input int aihp, input int dmg,
                             input int accu, input int roll);
      dp_if.p_hp     = 4'(php);
      dp_if.ai_hp    = 4'(aihp);
      dp_if.dmg      = 4'(dmg);
      dp_if.accu     = 4'(accu);
      dp_if.acc_roll = 4'(roll);
   endtask

   // One confirm press and the whole resulting turn, compared cycle by cycle
   // with the strobe trace the battle rules predict.
   task automatic play_turn(input int php, input int aihp, input int dmg,
                            input int accu, input int roll, input bit repulse);
      logic [5:0] exp_q[$];
      logic [5:0] got_q[$];
      bit         pl_hit;
      bit         ai_hit;
      bit         fin;
      int         lat;
      int         seen;
      set_inputs(php, aihp, dmg, accu, roll);
      if (m_p_win || m_ai_win || m_draw) begin
         seen = 0;
         go = 1'b1;
         tick();
         go = 1'b0;
         repeat (8) begin
            if (busy) seen++;
            tick();
         end
         check("done_ignores_go", 32'(seen), 32'd0);
         check("done_flags_held", 32'({p_win, ai_win, draw}),
               32'({m_p_win, m_ai_win, m_draw}));
         return;
      end

      // Expected trace from the rules of a turn.
      pl_hit = (accu >= roll);
      ai_hit = pl_hit;
      fin    = 1'b0;
      exp_q.push_back(6'b010001);                 // player select
      exp_q.push_back(6'b011001);                 // player eval, latch AI HP
      m_last_hit[0] = pl_hit;
      if (pl_hit) begin
         exp_q.push_back(6'b010101);              // damage the AI
         if (dmg >= aihp) begin
            m_p_win = 1'b1;
            fin     = 1'b1;
         end
      end
      if (!fin) begin
         exp_q.push_back(6'b100001);              // AI select
         exp_q.push_back(6'b100001);              // AI eval
         m_last_hit[1] = ai_hit;
         if (ai_hit) begin
            exp_q.push_back(6'b100011);           // damage the player
            if (dmg >= php) begin
               m_ai_win = 1'b1;
               fin      = 1'b1;
            end
         end
      end
      if (!fin) begin
         exp_q.push_back(6'b000000);              // turn end, RNGs released
         if (m_turns < CNT_MAX) m_turns++;
`ifdef TURN_LIMIT_EN
         if (m_turns == MAX_TURNS) m_draw = 1'b1;
`endif
      end

      // Press and measure how many edges it takes to leave WAIT_GO.
      go = 1'b1;
      tick();
      lat = 1;
      go = 1'b0;
      while (!busy && lat < 10) begin
         tick();
         lat++;
      end
      check("go_latency", 32'(lat), 32'd3);

      while (busy && got_q.size() < 16) begin
         got_q.push_back(strobes());
         if (repulse && got_q.size() == 1) go = 1'b1;
         if (repulse && got_q.size() == 2) go = 1'b0;
         tick();
      end
      go = 1'b0;
      check("trace_len", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("trace[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));

      check("last_hit", 32'(last_hit), 32'(m_last_hit));
      check("turn_cnt", 32'(turn_cnt), 32'(m_turns));
      check("win_draw", 32'({p_win, ai_win, draw}), 32'({m_p_win, m_ai_win, m_draw}));

      if (repulse) begin
         seen = 0;
         repeat (6) begin
            if (busy) seen++;
            tick();
         end
         check("busy_press_dropped", 32'(seen), 32'd0);
      end
   endtask

   initial begin
      int busy_cycles;
      int waited;
      int strays;
      set_inputs(15, 15, 3, 15, 0);
      do_reset();

      // Both sides hit, nobody falls: load, app_ai, app_pl in order.
      play_turn(15, 15, 3, 15, 0, 1'b0);
      check("first_turn_cnt", 32'(turn_cnt), 32'd1);
      check("first_last_hit", 32'(last_hit), 32'd3);
      // Double miss: five-cycle busy window, no writes.
      play_turn(15, 15, 3, 2, 9, 1'b0);
      check("miss_last_hit", 32'(last_hit), 32'd0);

      // Button held for 50 cycles gives a single turn.
      do_reset();
      set_inputs(15, 15, 3, 2, 9);
      busy_cycles = 0;
      go = 1'b1;
      repeat (50) begin
         tick();
         if (busy) busy_cycles++;
      end
      go = 1'b0;
      repeat (5) begin
         tick();
         if (busy) busy_cycles++;
      end
      m_turns = 1;
      check("hold_busy_cycles", 32'(busy_cycles), 32'd5);
      check("hold_turn_cnt", 32'(turn_cnt), 32'(m_turns));

      // Player KO on an exact-HP hit; later presses are ignored until reset.
      play_turn(15, 3, 3, 15, 0, 1'b0);
      check("ko_p_win", 32'(p_win), 32'd1);
      play_turn(15, 3, 3, 15, 0, 1'b0);
      do_reset();
      check("ko_cleared", 32'(p_win), 32'd0);

      // Reset during the AI evaluation cycle.
      set_inputs(15, 15, 1, 15, 0);
      go = 1'b1;
      tick();
      go = 1'b0;
      waited = 0;
      while (!dp_if.actr && waited < 20) begin
         tick();
         waited++;
      end
      check("reached_a_sel", 32'(dp_if.actr), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      check("abort_outputs",
            32'({busy, last_hit, p_win, ai_win, draw, turn_cnt, strobes()}), 32'd0);
      rst = 1'b1;
      model_reset();
      strays = 0;
      repeat (6) begin
         if (dp_if.app_pl_dmg || busy) strays++;
         tick();
      end
      check("abort_no_strobe", 32'(strays), 32'd0);

`ifdef TURN_LIMIT_EN
      // Turn limit: all misses until the draw.
      do_reset();
      repeat (3) play_turn(15, 15, 3, 2, 9, 1'b0);
      check("limit_draw", 32'({draw, busy, turn_cnt}), 32'({1'b1, 1'b0, 8'd3}));
`endif

      // Randomised turns; start a new battle whenever one has ended.
      do_reset();
      for (int n = 0; n < 40; n++) begin
         play_turn(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(15, 0)), bit'($urandom_range(1, 0)));
         if (m_p_win || m_ai_win || m_draw) begin
            play_turn(15, 15, 0, 15, 0, 1'b0);
            do_reset();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
